// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, control-flow
// redirect input, and the valid/ready handshake toward decode.
// "master" is the fetch unit; "slave" is the surrounding memory/decode side.
interface instr_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        halted;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        input  redirect, redirect_pc,
        output if_valid, if_pc, if_instr,
        input  if_ready,
        output halted
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        output redirect, redirect_pc,
        input  if_valid, if_pc, if_instr,
        output if_ready,
        input  halted
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, issues one outstanding word fetch at a
// time, buffers returned words with their PC in a small FIFO for decode,
// discards in-flight responses on redirect and stops fetching after ebreak.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    instr_fetch_if.master bus
);
    localparam int                PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int                CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);
    localparam logic [31:0]       EBREAK   = 32'h0010_0073;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2,
        S_HALT = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [31:0]       r_pc;
    logic [31:0]       w_pc_nxt;
    logic [31:0]       r_pend_pc;
    logic [31:0]       r_fifo_pc    [DEPTH];
    logic [31:0]       r_fifo_instr [DEPTH];
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_req;
    logic              w_grant;
    logic              w_push;
    logic              w_pop;
    logic              w_flush;
    logic              w_pend_load;
    logic              w_unused_lsb;

    // The low address bits of a redirect target are ignored by design.
    assign w_unused_lsb = ^bus.redirect_pc[1:0];

    // Request only while out of reset and the FIFO has a free slot, so every
    // response is guaranteed a place to land.
    assign w_req   = rst_n && (r_state == S_REQ) && (r_count < FULL_CNT);
    assign w_grant = w_req && bus.imem_gnt;

    assign bus.imem_req  = w_req;
    assign bus.imem_addr = r_pc;
    assign bus.if_valid  = (r_count != '0);
    assign bus.if_pc     = r_fifo_pc[r_rd_ptr];
    assign bus.if_instr  = r_fifo_instr[r_rd_ptr];
    assign bus.halted    = (r_state == S_HALT);

    // Next-state, PC and FIFO control; redirect overrides everything else.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_pend_load = 1'b0;
        w_push      = 1'b0;
        w_flush     = 1'b0;
        w_pop       = (r_count != '0) && bus.if_ready;

        case (r_state)
            S_REQ: begin
                if (w_grant) begin
                    w_pend_load = 1'b1;
                    w_pc_nxt    = r_pc + 32'd4;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.imem_rvalid) begin
                    w_push      = 1'b1;
                    w_state_nxt = (bus.imem_rdata == EBREAK) ? S_HALT : S_REQ;
                end
            end
            S_DROP: begin
                if (bus.imem_rvalid) begin
                    w_state_nxt = S_REQ;
                end
            end
            S_HALT: begin
                w_state_nxt = S_HALT;
            end
            default: begin
                w_state_nxt = S_REQ;
            end
        endcase

        if (bus.redirect) begin
            w_flush  = 1'b1;
            w_push   = 1'b0;
            w_pop    = 1'b0;
            w_pc_nxt = {bus.redirect_pc[31:2], 2'b00};
            case (r_state)
                // A grant in the redirect cycle is still an issued request
                // whose response must be swallowed.
                S_REQ:          w_state_nxt = w_grant ? S_DROP : S_REQ;
                S_WAIT, S_DROP: w_state_nxt = bus.imem_rvalid ? S_REQ : S_DROP;
                default:        w_state_nxt = S_REQ;
            endcase
        end
    end

    // State, PC and pending-request PC registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_REQ;
            r_pc      <= RESET_PC;
            r_pend_pc <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            if (w_pend_load) begin
                r_pend_pc <= r_pc;
            end
        end
    end

    // FIFO pointers and occupancy; flush empties the buffer in one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (w_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage; cleared on reset so the head reads zero until first push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_fifo_pc[i]    <= '0;
                r_fifo_instr[i] <= '0;
            end
        end else if (w_push) begin
            r_fifo_pc[r_wr_ptr]    <= r_pend_pc;
            r_fifo_instr[r_wr_ptr] <= bus.imem_rdata;
        end
    end
endmodule

// File: tb/tb_instr_fetch.sv
`timescale 1ns/1ps
module tb_instr_fetch;
    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] EBREAK   = 32'h0010_0073;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    instr_fetch_if bus();

    instr_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          n_vec = 0;
    int          n_err = 0;
    int          n_pops = 0;
    int          lat = 1;
    bit          ebreak_en = 1'b0;
    bit          g_flag = 1'b0;
    logic [31:0] g_addr = '0;
    ent_t        exp_q[$];

    function automatic logic [31:0] word_of(input logic [31:0] pc);
        if (ebreak_en && pc == 32'h8000_0010) return EBREAK;
        return pc ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic timeout(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: condition not reached within cycle budget", name);
    endtask

    // Memory responder: one response per grant, lat cycles after the grant edge.
    initial begin
        bit          m_pend;
        int          m_wcnt;
        logic [31:0] m_pc;
        m_pend = 1'b0;
        m_wcnt = 0;
        m_pc   = '0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
        forever begin
            @(posedge clk);
            #2;
            bus.imem_rvalid = 1'b0;
            if (!rst_n) begin
                m_pend = 1'b0;
            end else begin
                if (g_flag) begin
                    m_pend = 1'b1;
                    m_pc   = g_addr;
                    m_wcnt = lat - 1;
                end else if (m_pend && m_wcnt != 0) begin
                    m_wcnt--;
                end
                if (m_pend && m_wcnt == 0) begin
                    bus.imem_rvalid = 1'b1;
                    bus.imem_rdata  = word_of(m_pc);
                    m_pend = 1'b0;
                end
            end
        end
    end

    // Scoreboard and monitor: responses push expectations, decode pops compare.
    initial begin
        logic [31:0] exp_addr;
        logic [31:0] resp_pc;
        bit          out_flag;
        bit          cur_drop;
        bit          exp_halt;
        bit          grant;
        ent_t        e;
        exp_addr = RESET_PC;
        resp_pc  = '0;
        out_flag = 1'b0;
        cur_drop = 1'b0;
        exp_halt = 1'b0;
        forever begin
            @(negedge clk);
            grant  = rst_n && bus.imem_req && bus.imem_gnt;
            g_flag = grant;
            g_addr = bus.imem_addr;
            if (!rst_n) begin
                exp_q.delete();
                exp_addr = RESET_PC;
                out_flag = 1'b0;
                cur_drop = 1'b0;
                exp_halt = 1'b0;
            end else begin
                if (bus.if_valid && bus.if_ready && !bus.redirect) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL decode_unexpected: got pc %h instr %h, none expected",
                                 bus.if_pc, bus.if_instr);
                    end else begin
                        e = exp_q.pop_front();
                        chk("decode_pc", bus.if_pc, e.pc);
                        chk("decode_instr", bus.if_instr, e.instr);
                        n_pops++;
                    end
                end
                if (bus.imem_rvalid) begin
                    if (out_flag && !cur_drop && !bus.redirect) begin
                        exp_q.push_back({resp_pc, word_of(resp_pc)});
                        if (word_of(resp_pc) == EBREAK) exp_halt = 1'b1;
                    end
                    out_flag = 1'b0;
                end
                if (grant) begin
                    if (exp_halt) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL grant_after_halt: got request at %h, none expected", bus.imem_addr);
                    end
                    chk("grant_addr", bus.imem_addr, exp_addr);
                    resp_pc  = bus.imem_addr;
                    exp_addr = bus.imem_addr + 32'd4;
                    out_flag = 1'b1;
                    cur_drop = 1'b0;
                end
                if (bus.redirect) begin
                    exp_q.delete();
                    exp_halt = 1'b0;
                    if (out_flag) cur_drop = 1'b1;
                    exp_addr = {bus.redirect_pc[31:2], 2'b00};
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Directed stimulus.
    initial begin
        bit found;
        bus.imem_gnt    = 1'b1;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.if_ready    = 1'b1;
        rst_n = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_req", {31'd0, bus.imem_req}, 32'd0);
        chk("reset_addr", bus.imem_addr, RESET_PC);
        chk("reset_if_valid", {31'd0, bus.if_valid}, 32'd0);
        chk("reset_if_pc", bus.if_pc, 32'd0);
        chk("reset_if_instr", bus.if_instr, 32'd0);
        chk("reset_halted", {31'd0, bus.halted}, 32'd0);
        step();
        rst_n = 1'b1;
        #1;
        chk("first_req", {31'd0, bus.imem_req}, 32'd1);
        chk("first_addr", bus.imem_addr, RESET_PC);

        // Sequential fetch with zero-wait memory
        repeat (12) step();
        chk("t1_progress", {31'd0, (n_pops >= 3)}, 32'd1);

        // Decode stall fills the FIFO and stops requests
        bus.if_ready = 1'b0;
        repeat (10) step();
        @(negedge clk);
        chk("stall_req", {31'd0, bus.imem_req}, 32'd0);
        chk("stall_valid", {31'd0, bus.if_valid}, 32'd1);
        chk("stall_depth", exp_q.size(), DEPTH);
        step();
        bus.if_ready = 1'b1;
        repeat (10) step();

        // Redirect while waiting; late response must be discarded
        lat = 3;
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (bus.imem_req && bus.imem_gnt) found = 1'b1;
        end
        if (!found) timeout("t3_grant");
        step();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h8000_0103;
        step();
        bus.redirect = 1'b0;
        lat = 1;
        @(negedge clk);
        chk("t3_flush_valid", {31'd0, bus.if_valid}, 32'd0);
        chk("t3_drop_req", {31'd0, bus.imem_req}, 32'd0);
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (bus.imem_req && bus.imem_gnt) found = 1'b1;
        end
        if (!found) timeout("t3_regrant");
        chk("t3_next_addr", bus.imem_addr, 32'h8000_0100);
        repeat (6) step();

        // Redirect coinciding with a response and a decode pop
        bus.if_ready = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (bus.if_valid && bus.imem_req && bus.imem_gnt) found = 1'b1;
        end
        if (!found) timeout("t4_setup");
        step();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h8000_0300;
        bus.if_ready    = 1'b1;
        step();
        bus.redirect = 1'b0;
        @(negedge clk);
        chk("t4_flush_valid", {31'd0, bus.if_valid}, 32'd0);
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            if (bus.if_valid) found = 1'b1;
            else @(negedge clk);
        end
        if (!found) timeout("t4_first_valid");
        chk("t4_first_pc", bus.if_pc, 32'h8000_0300);
        repeat (4) step();

        // ebreak halts fetching; redirect restarts it
        ebreak_en       = 1'b1;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h8000_0008;
        step();
        bus.redirect = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (bus.halted) found = 1'b1;
        end
        if (!found) timeout("t5_halt");
        chk("t5_halted", {31'd0, bus.halted}, 32'd1);
        repeat (5) step();
        @(negedge clk);
        chk("t5_req_off", {31'd0, bus.imem_req}, 32'd0);
        chk("t5_drained", {31'd0, bus.if_valid}, 32'd0);
        chk("t5_sb_drained", exp_q.size(), 32'd0);
        step();
        ebreak_en       = 1'b0;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h8000_0200;
        step();
        bus.redirect = 1'b0;
        @(negedge clk);
        chk("t5_unhalt", {31'd0, bus.halted}, 32'd0);
        chk("t5_restart_req", {31'd0, bus.imem_req}, 32'd1);
        chk("t5_restart_addr", bus.imem_addr, 32'h8000_0200);
        repeat (6) step();

        // Asynchronous reset in the middle of a wait with entries buffered
        bus.if_ready = 1'b0;
        lat = 3;
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (bus.if_valid && bus.imem_req && bus.imem_gnt) found = 1'b1;
        end
        if (!found) timeout("t6_setup");
        step();
        rst_n = 1'b0;
        #1;
        chk("t6_valid", {31'd0, bus.if_valid}, 32'd0);
        chk("t6_req", {31'd0, bus.imem_req}, 32'd0);
        chk("t6_if_pc", bus.if_pc, 32'd0);
        repeat (2) step();
        lat = 1;
        bus.if_ready = 1'b1;
        rst_n = 1'b1;
        #1;
        chk("t6_req_after", {31'd0, bus.imem_req}, 32'd1);
        chk("t6_addr_after", bus.imem_addr, RESET_PC);
        repeat (8) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction fetch stage, directly upstream of the instruction decoder.
- Owns the PC. Issues word fetches to instruction memory over a request/grant + response-valid interface.
- Buffers returned words with their PC in a small FIFO. Presents them to decode through a valid/ready handshake.
- Handles control-flow redirects (flush + discard of in-flight response). Halts fetching after an ebreak word.

Parameters:
- RESET_PC, 32'h8000_0000: PC fetched first after reset.
- DEPTH, 2: fetch FIFO entries (power of two, ≥2).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- imem_req  output  1  fetch request valid.
- imem_addr  output  32  fetch byte address; bits [1:0] always 0.
- imem_gnt  input  1  memory accepts the request this cycle.
- imem_rvalid  input  1  response word valid; at most one per granted request, earliest the cycle after the grant.
- imem_rdata  input  32  response instruction word.
- redirect  input  1  control-flow change (branch/jump/trap).
- redirect_pc  input  32  new fetch PC; bits [1:0] ignored, treated as 0.
- if_valid  output  1  FIFO head valid toward decode.
- if_ready  input  1  decode accepts the head.
- if_pc  output  32  PC of the head entry.
- if_instr  output  32  instruction word of the head entry.
- halted  output  1  ebreak fetched; no further requests.

Behaviour:
- Reset (asynchronous, any state) sets:
  - state=REQ, pc=RESET_PC, FIFO empty.
  - imem_req=0, imem_addr=RESET_PC.
  - if_valid=0, if_pc=0, if_instr=0, halted=0.
- States: REQ, WAIT, DROP, HALT. At most one outstanding request.
- REQ:
  - imem_req=1 iff FIFO count<DEPTH. imem_addr=pc.
  - The first request is visible in the first cycle after rst_n rises.
  - req/addr stay stable until gnt, except on redirect.
  - On req&gnt: latch pend_pc=pc, pc<=pc+4 (mod 2^32, wraps at 32'hFFFF_FFFC->0), go WAIT.
- WAIT:
  - imem_req=0.
  - On rvalid: push {pend_pc, rdata}.
  - If rdata==32'h0010_0073, go HALT and set halted=1. Otherwise go REQ.
  - Space is guaranteed because a request is issued only when count<DEPTH.
- DROP:
  - imem_req=0.
  - On rvalid: discard the word, go REQ.
- HALT:
  - imem_req=0. FIFO keeps draining to decode.
  - Only reset or redirect leaves HALT.
- Redirect has highest priority:
  - Flush the FIFO; the same-cycle if_valid&if_ready pop is void.
  - pc<=redirect_pc & ~3. halted<=0.
  - Next state:
    - From WAIT without same-cycle rvalid: DROP.
    - From WAIT with same-cycle rvalid: the word is dropped, go REQ.
    - From REQ, DROP or HALT: REQ. DROP stays DROP if no rvalid arrives that cycle.
  - A grant coinciding with redirect in REQ counts as an issued request; the next state is DROP instead.
- FIFO:
  - Push and pop in the same cycle are legal; count is unchanged.
  - if_valid = count≠0. if_pc/if_instr = head entry (registered storage).
  - Head contents when empty are don't-care except after reset (0).
- Latency: grant cycle N, rvalid at N+k (k≥1) → if_valid at N+k+1.
- Peak throughput: one instruction every 2 cycles with zero-wait memory.
- Stall: with if_ready=0, the FIFO fills to DEPTH, then imem_req drops to 0 until a pop frees an entry.

Test Plan:
- Reset release, gnt tied 1, rvalid one cycle after each grant, if_ready=1 → addresses 8000_0000, 8000_0004, 8000_0008 in order; decode sees matching if_pc/if_instr pairs; no duplicates or gaps.
- if_ready=0 for 10 cycles → exactly DEPTH entries buffered, imem_req low afterwards. Raise if_ready → entries drain in order and fetch resumes at the next sequential PC.
- Redirect to 32'h8000_0103 while in WAIT; rvalid arrives 3 cycles later → late word never reaches decode; next request address 8000_0100; FIFO empty the cycle after redirect.
- Redirect in the same cycle as rvalid and as an if_valid&if_ready pop → both the word and the pop are discarded; next if_pc equals the redirect target.
- Fetch returns 32'h0010_0073 at PC 8000_0010 → halted=1, no further imem_req, ebreak delivered to decode. Redirect to 8000_0200 → halted=0 and fetch restarts at 8000_0200.
- Assert rst_n low mid-WAIT with 2 entries buffered → next cycle if_valid=0, imem_req=0. After release, the first request goes to RESET_PC; a stale rvalid is not expected after reset.
